// File: rtl/lfsr_random_gen.sv
// Pseudo-random source for game logic: XNOR Fibonacci LFSR plus a bounded
// request/valid draw engine returning a uniform value in [0, i_limit].
module lfsr_random_gen #(
    parameter int                LFSR_W    = 16,
    parameter int                OUT_W     = 4,
    parameter logic [LFSR_W-1:0] SEED      = '0,
    parameter int                MAX_TRIES = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_free_run,
    input  logic              i_seed_load,
    input  logic [LFSR_W-1:0] i_seed,
    input  logic              i_req,
    input  logic [OUT_W-1:0]  i_limit,
    output logic              o_busy,
    output logic              o_valid,
    output logic [OUT_W-1:0]  o_value,
    output logic              o_fallback,
    output logic [OUT_W-1:0]  o_raw
);

    localparam int TRY_W = (MAX_TRIES < 2) ? 1 : $clog2(MAX_TRIES);

    // Tap positions as a bit mask over a 32-bit word, 0-based.
    function automatic logic [31:0] f_tap_mask(input int w);
        case (w)
            8:       return 32'h0000_00B8;
            16:      return 32'h0000_B400;
            24:      return 32'h00E1_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_0000;
        endcase
    endfunction

    localparam logic [31:0]       TAP_MASK32 = f_tap_mask(LFSR_W);
    localparam logic [LFSR_W-1:0] TAP_MASK   = TAP_MASK32[LFSR_W-1:0];

    generate
        if (LFSR_W != 8 && LFSR_W != 16 && LFSR_W != 24 && LFSR_W != 32) begin : g_bad_width
            $error("lfsr_random_gen: LFSR_W must be 8, 16, 24 or 32");
        end
        if (OUT_W < 1 || OUT_W > LFSR_W) begin : g_bad_out
            $error("lfsr_random_gen: OUT_W must be in 1..LFSR_W");
        end
        if (MAX_TRIES < 1) begin : g_bad_tries
            $error("lfsr_random_gen: MAX_TRIES must be >= 1");
        end
        if (&SEED) begin : g_bad_seed
            $error("lfsr_random_gen: SEED must not be the all-ones lock-up state");
        end
    endgenerate

    function automatic logic [LFSR_W-1:0] f_step(input logic [LFSR_W-1:0] lfsr);
        return {lfsr[LFSR_W-2:0], ~(^(lfsr & TAP_MASK))};
    endfunction

    // All-ones would lock the XNOR register forever, so it maps to all-zeros.
    function automatic logic [LFSR_W-1:0] f_seed_fix(input logic [LFSR_W-1:0] seed);
        return (&seed) ? '0 : seed;
    endfunction

    // Smear the highest set bit downward: smallest 2^k-1 covering the limit.
    function automatic logic [OUT_W-1:0] f_mask(input logic [OUT_W-1:0] lim);
        logic [OUT_W-1:0] m;
        m = lim;
        for (int i = 1; i < OUT_W; i = i * 2) begin
            m = m | (m >> i);
        end
        return m;
    endfunction

    typedef enum logic {
        S_IDLE = 1'b0,
        S_DRAW = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LFSR_W-1:0]  r_lfsr;
    logic [OUT_W-1:0]   r_limit;
    logic [TRY_W-1:0]   r_tries;
    logic               r_valid;
    logic [OUT_W-1:0]   r_value;
    logic               r_fallback;

    logic [OUT_W-1:0]   w_mask;
    logic [OUT_W-1:0]   w_cand;
    logic               w_accept;
    logic               w_last_try;
    logic               w_start;
    logic               w_done;
    logic               w_drawing;
    logic [OUT_W-1:0]   w_value_nxt;
    logic               w_fallback_nxt;

    assign w_mask     = f_mask(r_limit);
    assign w_cand     = r_lfsr[OUT_W-1:0] & w_mask;
    assign w_accept   = (w_cand <= r_limit);
    assign w_last_try = (r_tries == TRY_W'(MAX_TRIES - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (i_req) w_state_nxt = S_DRAW;
            S_DRAW: if (w_accept || w_last_try) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_drawing      = (r_state == S_DRAW);
        w_start        = (r_state == S_IDLE) && i_req;
        w_done         = w_drawing && (w_accept || w_last_try);
        w_value_nxt    = w_accept ? w_cand : (w_cand >> 1);
        w_fallback_nxt = !w_accept;
    end

    // Seed load wins over stepping; a draw keeps the register moving.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lfsr <= SEED;
        end else if (i_seed_load) begin
            r_lfsr <= f_seed_fix(i_seed);
        end else if (i_free_run || w_drawing) begin
            r_lfsr <= f_step(r_lfsr);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_limit <= '0;
            r_tries <= '0;
        end else if (w_start) begin
            r_limit <= i_limit;
            r_tries <= '0;
        end else if (w_drawing && !w_accept && !w_last_try) begin
            r_tries <= r_tries + TRY_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid    <= 1'b0;
            r_value    <= '0;
            r_fallback <= 1'b0;
        end else begin
            r_valid <= w_done;
            if (w_done) begin
                r_value    <= w_value_nxt;
                r_fallback <= w_fallback_nxt;
            end
        end
    end

    assign o_busy     = w_drawing;
    assign o_valid    = r_valid;
    assign o_value    = r_value;
    assign o_fallback = r_fallback;
    assign o_raw      = r_lfsr[OUT_W-1:0];

endmodule

// File: tb/tb_lfsr_random_gen.sv
// Bench for lfsr_random_gen: directed scenarios with literal expectations plus
// a randomized run checked every cycle against a behavioural model.
module tb_lfsr_random_gen;

    localparam int LFSR_W    = 16;
    localparam int OUT_W     = 4;
    localparam int MAX_TRIES = 4;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic              i_free_run = 1'b0;
    logic              i_seed_load = 1'b0;
    logic [LFSR_W-1:0] i_seed = '0;
    logic              i_req = 1'b0;
    logic [OUT_W-1:0]  i_limit = '0;
    logic              o_busy;
    logic              o_valid;
    logic [OUT_W-1:0]  o_value;
    logic              o_fallback;
    logic [OUT_W-1:0]  o_raw;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    // Model state
    logic [15:0] m_lfsr;
    bit          m_busy;
    int          m_limit;
    int          m_tries;
    bit          m_valid;
    int          m_value;
    bit          m_fb;

    logic [3:0] exp_nib [12] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hF, 4'hF,
                                 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hE};

    lfsr_random_gen #(
        .LFSR_W(LFSR_W), .OUT_W(OUT_W), .SEED(16'h0000), .MAX_TRIES(MAX_TRIES)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_free_run(i_free_run),
        .i_seed_load(i_seed_load), .i_seed(i_seed), .i_req(i_req),
        .i_limit(i_limit), .o_busy(o_busy), .o_valid(o_valid),
        .o_value(o_value), .o_fallback(o_fallback), .o_raw(o_raw)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int mmask(input int lim);
        for (int k = 0; k <= OUT_W; k++) begin
            if ((1 << k) - 1 >= lim) return (1 << k) - 1;
        end
        return (1 << OUT_W) - 1;
    endfunction

    // Feedback is 1 when an even number of tap bits (16,14,13,11) are set.
    function automatic logic [15:0] mstep(input logic [15:0] l);
        int ones;
        ones = int'(l[15]) + int'(l[13]) + int'(l[12]) + int'(l[10]);
        return {l[14:0], ((ones % 2) == 0) ? 1'b1 : 1'b0};
    endfunction

    task automatic model_reset();
        m_lfsr  = 16'h0000;
        m_busy  = 0;
        m_limit = 0;
        m_tries = 0;
        m_valid = 0;
        m_value = 0;
        m_fb    = 0;
    endtask

    task automatic model_step();
        bit was_busy;
        int cand;
        if (!i_rst_n) return;
        was_busy = m_busy;
        m_valid  = 0;
        if (m_busy) begin
            cand = int'(m_lfsr[3:0]) & mmask(m_limit);
            if (cand <= m_limit) begin
                m_value = cand; m_fb = 0; m_valid = 1; m_busy = 0;
            end else begin
                m_tries++;
                if (m_tries == MAX_TRIES) begin
                    m_value = cand / 2; m_fb = 1; m_valid = 1; m_busy = 0;
                end
            end
        end else if (i_req) begin
            m_limit = int'(i_limit);
            m_tries = 0;
            m_busy  = 1;
        end
        if (i_seed_load)
            m_lfsr = (i_seed == 16'hFFFF) ? 16'h0000 : i_seed;
        else if (i_free_run || was_busy)
            m_lfsr = mstep(m_lfsr);
    endtask

    task automatic tick();
        @(posedge i_clk);
        model_step();
        #2;
    endtask

    always @(negedge i_clk) begin
        if (i_rst_n && cmp_en) begin
            chk("cmp_raw", 32'(o_raw), 32'(m_lfsr[3:0]));
            chk("cmp_busy", 32'(o_busy), 32'(m_busy));
            chk("cmp_valid", 32'(o_valid), 32'(m_valid));
            chk("cmp_value", 32'(o_value), 32'(m_value));
            if (m_valid) chk("cmp_fallback", 32'(o_fallback), 32'(m_fb));
        end
    end

    initial begin
        model_reset();
        tick(); tick();
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_value", 32'(o_value), 0);
        chk("rst_fallback", 32'(o_fallback), 0);
        chk("rst_raw", 32'(o_raw), 0);
        i_rst_n = 1'b1;
        cmp_en  = 1;

        // Free-run from seed 0
        i_free_run = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("t1_raw", 32'(o_raw), 32'(exp_nib[i]));
            if (i == 10) chk("t1_model_11", 32'(m_lfsr), 32'h07FF);
            if (i == 11) chk("t1_model_12", 32'(m_lfsr), 32'h0FFE);
        end
        i_free_run = 1'b0;

        // Lock-up seed maps to zero, then steps to one
        i_seed_load = 1'b1; i_seed = 16'hFFFF;
        tick();
        i_seed_load = 1'b0;
        chk("t2_raw_load", 32'(o_raw), 0);
        chk("t2_model_load", 32'(m_lfsr), 0);
        i_free_run = 1'b1;
        tick();
        i_free_run = 1'b0;
        chk("t2_raw_step", 32'(o_raw), 1);
        chk("t2_model_step", 32'(m_lfsr), 1);

        // First-attempt accept
        i_seed_load = 1'b1; i_seed = 16'h0004;
        tick();
        i_seed_load = 1'b0;
        i_req = 1'b1; i_limit = 4'd5;
        tick();
        i_req = 1'b0;
        chk("t3_busy_T1", 32'(o_busy), 1);
        chk("t3_valid_T1", 32'(o_valid), 0);
        tick();
        chk("t3_valid_T2", 32'(o_valid), 1);
        chk("t3_value", 32'(o_value), 4);
        chk("t3_fallback", 32'(o_fallback), 0);
        chk("t3_busy_T2", 32'(o_busy), 0);

        // Retry budget exhausted
        i_seed_load = 1'b1; i_seed = 16'h0007;
        tick();
        i_seed_load = 1'b0;
        i_req = 1'b1; i_limit = 4'd5;
        tick();
        i_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_wait_valid", 32'(o_valid), 0);
            chk("t4_wait_busy", 32'(o_busy), 1);
        end
        tick();
        chk("t4_valid", 32'(o_valid), 1);
        chk("t4_value", 32'(o_value), 3);
        chk("t4_fallback", 32'(o_fallback), 1);

        // Limit zero, back-to-back, request while busy
        i_seed_load = 1'b1; i_seed = 16'hA5C3;
        tick();
        i_seed_load = 1'b0;
        i_req = 1'b1; i_limit = 4'd0;
        tick();
        i_req = 1'b0; i_limit = 4'hF;
        tick();
        chk("t5_valid_T2", 32'(o_valid), 1);
        chk("t5_value_T2", 32'(o_value), 0);
        i_req = 1'b1; i_limit = 4'd0;
        tick();
        chk("t5_busy_T3", 32'(o_busy), 1);
        i_limit = 4'hF;
        tick();
        chk("t5_valid_T4", 32'(o_valid), 1);
        chk("t5_value_T4", 32'(o_value), 0);
        i_req = 1'b0;
        tick();
        chk("t5_busy_after", 32'(o_busy), 0);

        // Asynchronous reset in the middle of a draw
        i_seed_load = 1'b1; i_seed = 16'h0007;
        tick();
        i_seed_load = 1'b0;
        i_req = 1'b1; i_limit = 4'd5;
        tick();
        i_req = 1'b0;
        tick();
        #1;
        i_rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_busy", 32'(o_busy), 0);
        chk("t6_valid", 32'(o_valid), 0);
        chk("t6_raw", 32'(o_raw), 0);
        tick(); tick();
        i_rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t6_no_valid", 32'(o_valid), 0);
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            i_free_run  = ($urandom_range(0, 1) == 0);
            i_seed_load = ($urandom_range(0, 15) == 0);
            i_seed      = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            i_req       = ($urandom_range(0, 2) == 0);
            i_limit     = 4'($urandom);
            tick();
        end
        i_free_run = 1'b0; i_seed_load = 1'b0; i_req = 1'b0;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
